// File: rtl/operand_fetch_if.sv
// Decode-to-execute handshake bundle for the operand-fetch stage.
// The master drives instructions in and accepts operands; the slave is the stage itself.
interface operand_fetch_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_pc;
  logic [15:0]   in_inst;
  logic          in_wen;

  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_pc;
  logic [15:0]   out_inst;
  logic          out_wen;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;

  modport master (
    output in_valid, in_pc, in_inst, in_wen, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_wen, out_a, out_b
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_wen, out_a, out_b
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: one-entry slot, registered regfile read, writeback bypass, busy scoreboard.
// Optional macro R0_ZERO_EN turns r0 into a hard-wired zero register.
module operand_fetch #(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_fetch_if.slave       bus,
  input  logic                 flush,
  output logic [3:0]           raddr0_,
  output logic [3:0]           raddr1_,
  input  logic [DW-1:0]        rdata0,
  input  logic [DW-1:0]        rdata1,
  input  logic                 wb_wen,
  input  logic [3:0]           wb_waddr,
  input  logic [DW-1:0]        wb_wdata
);

  localparam bit R0_ZERO =
`ifdef R0_ZERO_EN
    1'b1;
`else
    1'b0;
`endif

  function automatic logic is_zero_reg(input logic [3:0] r);
    return R0_ZERO && (r == 4'd0);
  endfunction

  function automatic logic hazard(input logic [NREGS-1:0] bz, input logic [3:0] r,
                                  input logic wen, input logic [3:0] waddr);
    return bz[r] && !(wen && (waddr == r)) && !is_zero_reg(r);
  endfunction

  function automatic logic [DW-1:0] bypass(input logic [3:0] r, input logic [DW-1:0] rd,
                                           input logic wen, input logic [3:0] waddr,
                                           input logic [DW-1:0] wd);
    if (is_zero_reg(r))
      return '0;
    if (wen && (waddr == r))
      return wd;
    return rd;
  endfunction

  logic             vld_p1;
  logic [15:0]      pc_p1;
  logic [15:0]      inst_p1;
  logic             wen_p1;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  logic [3:0]       ra_p1;
  logic [3:0]       rb_p1;
  logic [3:0]       rt_p1;
  logic             haz_a;
  logic             haz_b;
  logic             issue;
  logic             accept;

  assign ra_p1 = inst_p1[11:8];
  assign rb_p1 = inst_p1[7:4];
  assign rt_p1 = inst_p1[3:0];

  assign haz_a = hazard(busy, ra_p1, wb_wen, wb_waddr);
  assign haz_b = hazard(busy, rb_p1, wb_wen, wb_waddr);

  assign bus.out_valid = vld_p1 && !haz_a && !haz_b && !flush;
  assign issue         = bus.out_valid && bus.out_ready;
  // Reset also blocks accepts so the read addresses sit at zero while rst_n is low.
  assign bus.in_ready  = rst_n && !flush && (!vld_p1 || issue);
  assign accept        = bus.in_valid && bus.in_ready;

  // The regfile latches these every edge, so a held slot keeps its own operands fresh.
  assign raddr0_ = accept ? bus.in_inst[11:8] : ra_p1;
  assign raddr1_ = accept ? bus.in_inst[7:4]  : rb_p1;

  assign bus.out_pc   = pc_p1;
  assign bus.out_inst = inst_p1;
  assign bus.out_wen  = wen_p1;
  assign bus.out_a    = bypass(ra_p1, rdata0, wb_wen, wb_waddr, wb_wdata);
  assign bus.out_b    = bypass(rb_p1, rdata1, wb_wen, wb_waddr, wb_wdata);

  // Writeback clears first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_wen)
      busy_nxt[wb_waddr] = 1'b0;
    if (issue && wen_p1 && !is_zero_reg(rt_p1))
      busy_nxt[rt_p1] = 1'b1;
  end

  // p0 -> p1: decoded instruction enters the operand slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      inst_p1 <= '0;
      wen_p1  <= 1'b0;
      busy    <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1  <= 1'b1;
        pc_p1   <= bus.in_pc;
        inst_p1 <= bus.in_inst;
        wen_p1  <= bus.in_wen;
      end else if (issue) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized run,
// compared every cycle against a rule-level model of slot, scoreboard and register values.
module tb_operand_fetch;

  localparam bit R0Z =
`ifdef R0_ZERO_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  raddr0_, raddr1_;
  logic [15:0] rdata0 = '0;
  logic [15:0] rdata1 = '0;
  logic        wb_wen;
  logic [3:0]  wb_waddr;
  logic [15:0] wb_wdata;

  operand_fetch_if #(.DW(16)) ifc();

  operand_fetch #(.NREGS(16), .DW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .flush    (flush),
    .raddr0_  (raddr0_),
    .raddr1_  (raddr1_),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .wb_wen   (wb_wen),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: architectural registers, set of in-flight destinations, held slot.
  bit [15:0] regs [16];
  bit [15:0] mbusy;
  bit        ms_v;
  bit [15:0] ms_pc, ms_inst;
  bit        ms_wen;
  bit        e_issue, e_accept;
  logic [3:0] cap_r0, cap_r1;

  function automatic bit wb_hits(input logic [3:0] r);
    return wb_wen && (wb_waddr == r);
  endfunction

  function automatic bit hz(input logic [3:0] r);
    return mbusy[r] && !wb_hits(r) && !(R0Z && r == 4'd0);
  endfunction

  function automatic bit [15:0] opnd(input logic [3:0] r);
    if (R0Z && r == 4'd0) return 16'h0000;
    if (wb_hits(r)) return wb_wdata;
    return regs[r];
  endfunction

  always @(negedge clk) begin
    bit ev, er;
    logic [3:0] ra, rb, e_r0, e_r1;
    ra = ms_inst[11:8];
    rb = ms_inst[7:4];
    ev = ms_v && !hz(ra) && !hz(rb) && !flush;
    e_issue  = ev && ifc.out_ready;
    er = rst_n && !flush && (!ms_v || e_issue);
    e_accept = ifc.in_valid && er;
    e_r0 = e_accept ? ifc.in_inst[11:8] : ra;
    e_r1 = e_accept ? ifc.in_inst[7:4]  : rb;
    cap_r0 = raddr0_;
    cap_r1 = raddr1_;
    chk("out_valid", ifc.out_valid, ev);
    chk("in_ready",  ifc.in_ready,  er);
    chk("raddr0",    raddr0_,       e_r0);
    chk("raddr1",    raddr1_,       e_r1);
    chk("out_pc",    ifc.out_pc,    ms_pc);
    chk("out_inst",  ifc.out_inst,  ms_inst);
    chk("out_wen",   ifc.out_wen,   ms_wen);
    if (ms_v) begin
      chk("out_a", ifc.out_a, opnd(ra));
      chk("out_b", ifc.out_b, opnd(rb));
    end
  end

  // Regfile (write-first, address taken from the DUT) and model state update.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_v    <= 1'b0;
      ms_pc   <= '0;
      ms_inst <= '0;
      ms_wen  <= 1'b0;
      mbusy   <= '0;
    end else begin
      if (wb_wen) begin
        mbusy[wb_waddr] <= 1'b0;
        regs[wb_waddr]  <= wb_wdata;
      end
      if (e_issue && ms_wen && !(R0Z && ms_inst[3:0] == 4'd0))
        mbusy[ms_inst[3:0]] <= 1'b1;
      rdata0 <= wb_hits(cap_r0) ? wb_wdata : regs[cap_r0];
      rdata1 <= wb_hits(cap_r1) ? wb_wdata : regs[cap_r1];
      if (flush) begin
        ms_v <= 1'b0;
      end else if (e_accept) begin
        ms_v    <= 1'b1;
        ms_pc   <= ifc.in_pc;
        ms_inst <= ifc.in_inst;
        ms_wen  <= ifc.in_wen;
      end else if (e_issue) begin
        ms_v <= 1'b0;
      end
    end
  end

  logic [15:0] pc_ctr = 16'h0100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    flush         = 1'b0;
    wb_wen        = 1'b0;
  endtask

  task automatic wb(input logic [3:0] a, input logic [15:0] d);
    wb_wen   = 1'b1;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  task automatic push(input logic [15:0] inst, input logic wen);
    ifc.in_valid = 1'b1;
    ifc.in_inst  = inst;
    ifc.in_wen   = wen;
    ifc.in_pc    = pc_ctr;
    pc_ctr       = pc_ctr + 16'd2;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ifc.in_pc = '0; ifc.in_inst = '0; ifc.in_wen = 1'b0;
    wb_waddr = '0; wb_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ifc.out_valid, 1'b0);
    chk("rst_raddr0", raddr0_, 4'd0);
    chk("rst_out_pc", ifc.out_pc, 16'h0000);
    rst_n = 1'b1;

    // Plain operand read
    wb(4'd3, 16'h1234); tick();
    wb(4'd5, 16'h00FF); tick();
    wb_wen = 1'b0; push(16'h1351, 1'b0);
    #3 chk("t2_in_ready", ifc.in_ready, 1'b1); chk("t2_raddr0", raddr0_, 4'd3);
    tick();
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    #3 chk("t2_valid", ifc.out_valid, 1'b1);
    chk("t2_a", ifc.out_a, 16'h1234); chk("t2_b", ifc.out_b, 16'h00FF);
    tick();

    // RAW hazard on r4 released by writeback bypass
    push(16'h2124, 1'b1); tick();
    push(16'h3406, 1'b0);
    #3 chk("t3_prod_valid", ifc.out_valid, 1'b1);
    tick();
    ifc.in_valid = 1'b0;
    #3 chk("t3_stall0", ifc.out_valid, 1'b0); tick();
    #3 chk("t3_stall1", ifc.out_valid, 1'b0); tick();
    wb(4'd4, 16'hBEEF);
    #3 chk("t3_release", ifc.out_valid, 1'b1); chk("t3_bypass", ifc.out_a, 16'hBEEF);
    tick();

    // Downstream stall with a write to the held source
    wb_wen = 1'b0; ifc.out_ready = 1'b0; push(16'h4357, 1'b0); tick();
    push(16'h5111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wb(4'd3, 16'h0042); else wb_wen = 1'b0;
      #3 chk("t4_raddr0", raddr0_, 4'd3); chk("t4_in_ready", ifc.in_ready, 1'b0);
      tick();
    end
    wb_wen = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    #3 chk("t4_a", ifc.out_a, 16'h0042); chk("t4_valid", ifc.out_valid, 1'b1);
    tick();

    // Full throughput, then flush of a held instruction
    push(16'h689A, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      push(16'h689A, 1'b0);
      #3 chk("t5_valid", ifc.out_valid, 1'b1); chk("t5_pc", ifc.out_pc, pc_ctr - 16'd4);
      tick();
    end
    push(16'h7896, 1'b1);
    #3 chk("t5_valid", ifc.out_valid, 1'b1); tick();
    push(16'h8ABC, 1'b0);
    #3 chk("t5_prod_issue", ifc.out_valid, 1'b1); tick();
    flush = 1'b1; push(16'h9DEF, 1'b0);
    #3 chk("t5_flush_valid", ifc.out_valid, 1'b0); chk("t5_flush_ready", ifc.in_ready, 1'b0);
    tick();
    flush = 1'b0; ifc.in_valid = 1'b0;
    #3 chk("t5_after_flush", ifc.out_valid, 1'b0); tick();
    push(16'h96A0, 1'b0); tick();
    ifc.in_valid = 1'b0;
    #3 chk("t5_busy_kept", ifc.out_valid, 1'b0); tick();
    wb(4'd6, 16'h5A5A);
    #3 chk("t5_busy_release", ifc.out_valid, 1'b1); chk("t5_a", ifc.out_a, 16'h5A5A);
    tick();

`ifdef R0_ZERO_EN
    wb(4'd0, 16'h7777); tick();
    wb_wen = 1'b0; ifc.out_ready = 1'b0; push(16'hA000, 1'b1); tick();
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; wb(4'd0, 16'h1111);
    #3 chk("t6_valid", ifc.out_valid, 1'b1);
    chk("t6_a", ifc.out_a, 16'h0000); chk("t6_b", ifc.out_b, 16'h0000);
    tick();
    wb_wen = 1'b0; push(16'hB0C1, 1'b0); tick();
    ifc.in_valid = 1'b0;
    #3 chk("t6_no_busy0", ifc.out_valid, 1'b1); tick();
`else
    wb(4'd0, 16'h7777); tick();
    wb_wen = 1'b0; ifc.out_ready = 1'b0; push(16'hA001, 1'b1); tick();
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    #3 chk("t6_a", ifc.out_a, 16'h7777); chk("t6_b", ifc.out_b, 16'h7777);
    tick();
`endif

    // Asynchronous reset in the middle of a hazard stall
    push(16'hC007, 1'b1); ifc.out_ready = 1'b0; tick();
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; tick();
    push(16'hD712, 1'b0); ifc.out_ready = 1'b0; tick();
    push(16'hE333, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("t1_valid", ifc.out_valid, 1'b0); chk("t1_raddr0", raddr0_, 4'd0);
    chk("t1_out_inst", ifc.out_inst, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1; idle(); push(16'hF712, 1'b0); tick();
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    #3 chk("t1_busy_cleared", ifc.out_valid, 1'b1); tick();

    // Randomized traffic on a narrow register window to provoke hazards
    for (int i = 0; i < 2500; i++) begin
      ifc.in_valid  = ($urandom_range(0, 9) < 7);
      ifc.in_inst   = 16'($urandom) & 16'hF777;
      ifc.in_wen    = 1'($urandom_range(0, 1));
      ifc.in_pc     = 16'($urandom);
      ifc.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 19) == 0);
      wb_wen        = ($urandom_range(0, 9) < 4);
      wb_waddr      = 4'($urandom_range(0, 7));
      wb_wdata      = 16'($urandom);
      rst_n         = (i != 1200);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
